wc_2_3_host: RTL and testbench



---
 rtl/wc_2_3_host.sv | 137 +++++++++++++
 tb/tb_wc_2_3_host.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wc_2_3_host.sv
// rtl/wc_2_3_host.sv - host-side D/Z link driver for the WC_2_3 Winograd F(2,3) chip
// Define WC_HOST_CHECKSUM_EN to append a checksum word to both request and response frames.

module wc_2_3_host #(
  parameter int W       = 10,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7*W-1:0] in_data,
  output logic [W-1:0]   D,
  input  logic [W-1:0]   Z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_y0,
  output logic [W-1:0]   out_y1,
  output logic           out_err
);

  localparam logic [W-1:0] HDR = {W{1'b1}};
`ifdef WC_HOST_CHECKSUM_EN
  localparam int NTX = 8;
  localparam logic [1:0] RX_LAST = 2'd2;
`else
  localparam int NTX = 7;
  localparam logic [1:0] RX_LAST = 2'd1;
`endif
  localparam logic [2:0] IDX_LAST = 3'(NTX - 1);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_DATA, WAIT_HDR, RECV, HOLD} state_t;

  state_t       state;
  logic [W-1:0] tile [NTX];
  logic [W-1:0] z_q;
  logic [2:0]   idx;
  logic [1:0]   ridx;
  logic [9:0]   tmo;
  logic         rx_bad;

  // Gated by rst so the tile is never offered acceptance while reset is held.
  assign in_ready = (state == IDLE) && !rst;

`ifdef WC_HOST_CHECKSUM_EN
  logic [W-1:0] in_sum;

  always_comb begin
    in_sum = '0;
    for (int i = 0; i < 7; i++) in_sum = in_sum + in_data[i*W +: W];
  end

  assign rx_bad = (z_q != W'(out_y0 + out_y1));
`else
  assign rx_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int i = 0; i < 7; i++) tile[i] <= in_data[i*W +: W];
`ifdef WC_HOST_CHECKSUM_EN
      tile[7] <= in_sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      D         <= '0;
      z_q       <= '0;
      idx       <= '0;
      ridx      <= '0;
      tmo       <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_y0    <= '0;
      out_y1    <= '0;
    end else begin
      z_q <= Z;
      D   <= '0;
      case (state)
        IDLE: begin
          if (in_valid) state <= SEND_HDR;
        end
        SEND_HDR: begin
          D     <= HDR;
          idx   <= '0;
          state <= SEND_DATA;
        end
        SEND_DATA: begin
          D <= tile[idx];
          if (idx == IDX_LAST) begin
            tmo   <= '0;
            state <= WAIT_HDR;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        WAIT_HDR: begin
          // A header on the limit cycle takes priority over the timeout.
          if (z_q == HDR) begin
            ridx  <= '0;
            state <= RECV;
          end else if (tmo == TMO_LAST) begin
            out_y0    <= '0;
            out_y1    <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            tmo <= tmo + 10'd1;
          end
        end
        RECV: begin
          if (ridx == 2'd0) out_y0 <= z_q;
          if (ridx == 2'd1) out_y1 <= z_q;
          ridx <= ridx + 2'd1;
          if (ridx == RX_LAST) begin
            out_err   <= rx_bad;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wc_2_3_host.sv
// tb/tb_wc_2_3_host.sv - randomized self-checking bench for wc_2_3_host with a chip-side reply model
module tb_wc_2_3_host;

  localparam int W   = 10;
  localparam int TMO = 8;
  localparam logic [W-1:0] HDR = 10'h3FF;
`ifdef WC_HOST_CHECKSUM_EN
  localparam int NTX = 8;
`else
  localparam int NTX = 7;
`endif
  localparam int NFR = NTX + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7*W-1:0] in_data = '0;
  logic [W-1:0]   D;
  logic [W-1:0]   Z = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_y0;
  logic [W-1:0]   out_y1;
  logic           out_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] cap [NFR];
  bit acc_ok;
  int offer_waits;
  int lat;

  always #5 clk = ~clk;

  wc_2_3_host #(.W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .D(D), .Z(Z), .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1), .out_err(out_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] wd(input logic [7*W-1:0] t, input int i);
    return t[i*W +: W];
  endfunction

  function automatic logic [7*W-1:0] mk(input int d0, d1, d2, d3, g0, g1, g2);
    return {W'(g2), W'(g1), W'(g0), W'(d3), W'(d2), W'(d1), W'(d0)};
  endfunction

  function automatic logic [7*W-1:0] rand_tile();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[7*W-1:0];
  endfunction

  // Chip behaviour: F(2,3) correlation of d with g, mod 2^W.
  function automatic logic [W-1:0] ref_y0(input logic [7*W-1:0] t);
    int s;
    s = int'(wd(t,0))*int'(wd(t,4)) + int'(wd(t,1))*int'(wd(t,5)) + int'(wd(t,2))*int'(wd(t,6));
    return W'(s % (1 << W));
  endfunction

  function automatic logic [W-1:0] ref_y1(input logic [7*W-1:0] t);
    int s;
    s = int'(wd(t,1))*int'(wd(t,4)) + int'(wd(t,2))*int'(wd(t,5)) + int'(wd(t,3))*int'(wd(t,6));
    return W'(s % (1 << W));
  endfunction

  function automatic logic [W-1:0] exp_word(input logic [7*W-1:0] t, input int k);
    int s;
    if (k == 0) return HDR;
    if (k >= 1 && k <= 7) return wd(t, k-1);
    if (NTX == 8 && k == 8) begin
      s = 0;
      for (int i = 0; i < 7; i++) s += int'(wd(t, i));
      return W'(s % (1 << W));
    end
    return '0;
  endfunction

  task automatic offer(input logic [7*W-1:0] t);
    in_data = t;
    in_valid = 1'b1;
    acc_ok = 1'b0;
    offer_waits = 0;
    for (int i = 0; i < 50 && !acc_ok; i++) begin
      acc_ok = in_ready;
      step;
      if (!acc_ok) offer_waits++;
    end
    in_valid = 1'b0;
  endtask

  task automatic transact(input logic [7*W-1:0] t, input logic [W-1:0] y0, input logic [W-1:0] y1,
                          input int dly, input bit bad_cs);
    offer(t);
    for (int k = 0; k < NFR; k++) begin
      step;
      cap[k] = D;
    end
    for (int i = 0; i < dly; i++) begin
      Z = '0;
      step;
    end
    Z = HDR; step;
    Z = y0;  step;
    Z = y1;  step;
    if (NTX == 8) begin
      Z = W'(y0 + y1) ^ W'(bad_cs);
      step;
    end
    Z = '0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step;
      lat++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    step; step; step;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (D !== '0) begin errors++; $display("FAIL reset_D got %h want 000", D); end
    checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL reset_out got valid=%b err=%b want 0 0", out_valid, out_err); end
    checks++; if (out_y0 !== '0 || out_y1 !== '0) begin errors++; $display("FAIL reset_y got %h %h want 000 000", out_y0, out_y1); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    logic [7*W-1:0] t;
    t = mk(1, 2, 3, 4, 1, 0, 1);
    transact(t, 10'd4, 10'd6, 5, 1'b0);
    checks++; if (!acc_ok) begin errors++; $display("FAIL basic_accept got 0 want 1"); end
    for (int k = 0; k < NFR; k++) begin
      checks++; if (cap[k] !== exp_word(t, k)) begin errors++; $display("FAIL basic_frame[%0d] got %h want %h", k, cap[k], exp_word(t, k)); end
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_latency got %0d want 1", lat); end
    checks++; if (out_y0 !== 10'd4 || out_y1 !== 10'd6) begin errors++; $display("FAIL basic_y got %h %h want 004 006", out_y0, out_y1); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", out_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_in_ready got %b want 0", in_ready); end
    release_result;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_timeout;
    int early;
    int bad;
    offer(rand_tile());
    for (int k = 0; k < NFR; k++) step;
    early = 0;
    for (int i = 0; i < TMO - 2; i++) begin
      step;
      if (out_valid) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL timeout_early got %0d cycles valid want 0", early); end
    step;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL timeout_valid got %b want 1", out_valid); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", out_err); end
    checks++; if (out_y0 !== '0 || out_y1 !== '0) begin errors++; $display("FAIL timeout_y got %h %h want 000 000", out_y0, out_y1); end
    release_result;
    bad = 0;
    Z = HDR;    step; if (out_valid || !in_ready || D !== '0) bad++;
    Z = 10'h155; step; if (out_valid || !in_ready || D !== '0) bad++;
    Z = 10'h2AA; step; if (out_valid || !in_ready || D !== '0) bad++;
    Z = '0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (out_valid || !in_ready || D !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL late_hdr_ignored got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_hdr_vs_timeout;
    logic [7*W-1:0] t;
    t = rand_tile();
    transact(t, ref_y0(t), ref_y1(t), TMO - 3, 1'b0);
    checks++; if (lat !== 1 || out_err !== 1'b0) begin errors++; $display("FAIL edge_hdr_wins got lat=%0d err=%b want 1 0", lat, out_err); end
    checks++; if (out_y0 !== ref_y0(t) || out_y1 !== ref_y1(t)) begin errors++; $display("FAIL edge_hdr_y got %h %h want %h %h", out_y0, out_y1, ref_y0(t), ref_y1(t)); end
    release_result;
    t = rand_tile();
    transact(t, ref_y0(t), ref_y1(t), TMO - 2, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin errors++; $display("FAIL edge_late_timeout got valid=%b err=%b want 1 1", out_valid, out_err); end
    checks++; if (out_y0 !== '0 || out_y1 !== '0) begin errors++; $display("FAIL edge_late_y got %h %h want 000 000", out_y0, out_y1); end
    release_result;
  endtask

  task automatic test_hdr_data;
    logic [7*W-1:0] t;
    t = mk(1023, int'($urandom_range(0, 1023)), 1023, 7, 1023, 3, 1023);
    transact(t, HDR, HDR, int'($urandom_range(0, TMO - 3)), 1'b0);
    for (int k = 0; k < NFR; k++) begin
      checks++; if (cap[k] !== exp_word(t, k)) begin errors++; $display("FAIL hdrdata_frame[%0d] got %h want %h", k, cap[k], exp_word(t, k)); end
    end
    checks++; if (lat !== 1 || out_err !== 1'b0) begin errors++; $display("FAIL hdrdata_done got lat=%0d err=%b want 1 0", lat, out_err); end
    checks++; if (out_y0 !== HDR || out_y1 !== HDR) begin errors++; $display("FAIL hdrdata_y got %h %h want 3ff 3ff", out_y0, out_y1); end
    release_result;
  endtask

  task automatic test_random;
    logic [7*W-1:0] t;
    for (int n = 0; n < 6; n++) begin
      t = rand_tile();
      transact(t, ref_y0(t), ref_y1(t), int'($urandom_range(0, TMO - 3)), 1'b0);
      for (int k = 0; k < NFR; k++) begin
        checks++; if (cap[k] !== exp_word(t, k)) begin errors++; $display("FAIL rand%0d_frame[%0d] got %h want %h", n, k, cap[k], exp_word(t, k)); end
      end
      checks++; if (lat !== 1) begin errors++; $display("FAIL rand%0d_latency got %0d want 1", n, lat); end
      checks++; if (out_y0 !== ref_y0(t) || out_y1 !== ref_y1(t) || out_err !== 1'b0) begin
        errors++; $display("FAIL rand%0d_result got %h %h %b want %h %h 0", n, out_y0, out_y1, out_err, ref_y0(t), ref_y1(t));
      end
      repeat ($urandom_range(0, 3)) step;
      release_result;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rand%0d_next_ready got %b want 1", n, in_ready); end
    end
  endtask

  task automatic test_backpressure;
    logic [7*W-1:0] t, t2;
    logic [W-1:0] y0e, y1e;
    int bad;
    t = rand_tile();
    y0e = ref_y0(t);
    y1e = ref_y1(t);
    transact(t, y0e, y1e, int'($urandom_range(0, TMO - 3)), 1'b0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bp_latency got %0d want 1", lat); end
    t2 = rand_tile();
    in_data = t2;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (out_valid !== 1'b1 || out_y0 !== y0e || out_y1 !== y1e || out_err !== 1'b0 || in_ready !== 1'b0 || D !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    transact(t2, ref_y0(t2), ref_y1(t2), int'($urandom_range(0, TMO - 3)), 1'b0);
    checks++; if (offer_waits !== 0 || !acc_ok) begin errors++; $display("FAIL bp_b2b_accept got waits=%0d want 0", offer_waits); end
    for (int k = 0; k < NFR; k++) begin
      checks++; if (cap[k] !== exp_word(t2, k)) begin errors++; $display("FAIL bp_frame[%0d] got %h want %h", k, cap[k], exp_word(t2, k)); end
    end
    checks++; if (out_y0 !== ref_y0(t2) || out_y1 !== ref_y1(t2) || out_err !== 1'b0) begin
      errors++; $display("FAIL bp_result got %h %h %b want %h %h 0", out_y0, out_y1, out_err, ref_y0(t2), ref_y1(t2));
    end
    release_result;
  endtask

  task automatic test_reset_mid;
    logic [7*W-1:0] t;
    int seen;
    t = rand_tile();
    offer(t);
    step; step; step;
    checks++; if (D !== wd(t, 1)) begin errors++; $display("FAIL rstmid_d1 got %h want %h", D, wd(t, 1)); end
    rst = 1'b1;
    step;
    checks++; if (D !== '0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_abort got D=%h ready=%b want 000 0", D, in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    seen = 0;
    Z = HDR;   step; if (out_valid) seen++;
    Z = 10'd5; step; if (out_valid) seen++;
    Z = 10'd6; step; if (out_valid) seen++;
    Z = '0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (out_valid || D !== '0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad cycles want 0", seen); end
    t = rand_tile();
    transact(t, ref_y0(t), ref_y1(t), int'($urandom_range(0, TMO - 3)), 1'b0);
    for (int k = 0; k < NFR; k++) begin
      checks++; if (cap[k] !== exp_word(t, k)) begin errors++; $display("FAIL rstmid_frame[%0d] got %h want %h", k, cap[k], exp_word(t, k)); end
    end
    checks++; if (lat !== 1 || out_y0 !== ref_y0(t) || out_y1 !== ref_y1(t) || out_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_result got lat=%0d %h %h %b want 1 %h %h 0", lat, out_y0, out_y1, out_err, ref_y0(t), ref_y1(t));
    end
    release_result;
  endtask

`ifdef WC_HOST_CHECKSUM_EN
  task automatic test_checksum;
    logic [7*W-1:0] t;
    t = mk(1, 2, 3, 4, 1, 0, 1);
    transact(t, 10'd4, 10'd6, 2, 1'b0);
    checks++; if (cap[8] !== 10'd12) begin errors++; $display("FAIL cs_tx_word got %h want 00c", cap[8]); end
    checks++; if (lat !== 1 || out_err !== 1'b0) begin errors++; $display("FAIL cs_good got lat=%0d err=%b want 1 0", lat, out_err); end
    release_result;
    transact(t, 10'd4, 10'd6, 2, 1'b1);
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL cs_bad_err got %b want 1", out_err); end
    checks++; if (out_y0 !== 10'd4 || out_y1 !== 10'd6) begin errors++; $display("FAIL cs_bad_y got %h %h want 004 006", out_y0, out_y1); end
    release_result;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_timeout;
    test_hdr_vs_timeout;
    test_hdr_data;
    test_random;
    test_backpressure;
    test_reset_mid;
`ifdef WC_HOST_CHECKSUM_EN
    test_checksum;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
